core_status_collector: RTL and testbench

//   End-of-test responder for the quad-core system: each core reports completion through a

---
 rtl/core_status_collector.sv | 158 +++++++++++++++
 tb/tb_core_status_collector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/core_status_collector.sv
// rtl/core_status_collector.sv - end-of-test mailbox arbiter and PASS/FAIL/TIMEOUT resolver
// Optional console output enabled by defining COLLECTOR_CONSOLE_EN.
module core_status_collector #(
  parameter int NUM_CORES      = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_wr_valid,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wr_data,
  output logic [NUM_CORES-1:0]          core_wr_ready,
  output logic [NUM_CORES-1:0]          core_done_mask,
  output logic                          all_done,
  output logic                          test_pass,
  output logic                          test_fail,
  output logic                          timeout,
  output logic [$clog2(NUM_CORES)-1:0]  fail_core,
  output logic [DATA_W-2:0]             fail_code,
`ifdef COLLECTOR_CONSOLE_EN
  output logic                          char_valid,
  output logic [7:0]                    char_data,
`endif
  output logic [CNT_W-1:0]              cycle_count
);

  localparam int IDX_W = $clog2(NUM_CORES);
  localparam logic [IDX_W:0]   NC       = (IDX_W+1)'(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_CORES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [NUM_CORES-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]       fail_core_q, fail_core_d;
  logic [DATA_W-2:0]      fail_code_q, fail_code_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_CORES-1:0]   grant;
  logic [IDX_W-1:0]       gidx;
  logic                   found;
  logic [IDX_W:0]         sum;
  logic [DATA_W-1:0]      word;
  logic                   accept;

  // Round-robin search starting at rr_q; first requester found wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      sum = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (sum >= NC) sum = sum - NC;
      if (!found && core_wr_valid[sum[IDX_W-1:0]]) begin
        found = 1'b1;
        gidx  = sum[IDX_W-1:0];
        grant[sum[IDX_W-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) word = core_wr_data[i*DATA_W +: DATA_W];
    end
  end

  assign accept        = found;
  assign core_wr_ready = grant;

`ifdef COLLECTOR_CONSOLE_EN
  logic       char_valid_q, char_valid_d;
  logic [7:0] char_data_q, char_data_d;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    mask_d      = mask_q;
    fail_core_d = fail_core_q;
    fail_code_d = fail_code_q;
    cnt_d       = cnt_q;
`ifdef COLLECTOR_CONSOLE_EN
    char_valid_d = 1'b0;
    char_data_d  = char_data_q;
`endif
    if (accept) rr_d = (gidx == LAST) ? '0 : gidx + 1'b1;
    if (state_q == S_RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TMO_LAST) state_d = S_TIMEOUT;
      // A resolving accept overrides the timeout decided in the same cycle.
      if (accept && word[0] && !mask_q[gidx]) begin
        if (word[DATA_W-1:1] == '0) begin
          mask_d = mask_q | grant;
          if (&(mask_q | grant)) state_d = S_PASS;
        end else begin
          state_d     = S_FAIL;
          fail_core_d = gidx;
          fail_code_d = word[DATA_W-1:1];
        end
      end
`ifdef COLLECTOR_CONSOLE_EN
      if (accept && !word[0]) begin
        char_valid_d = 1'b1;
        char_data_d  = word[7:0];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      rr_q        <= '0;
      mask_q      <= '0;
      fail_core_q <= '0;
      fail_code_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      mask_q      <= mask_d;
      fail_core_q <= fail_core_d;
      fail_code_q <= fail_code_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef COLLECTOR_CONSOLE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_valid_q <= 1'b0;
      char_data_q  <= '0;
    end else begin
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
    end
  end

  assign char_valid = char_valid_q;
  assign char_data  = char_data_q;
`endif

  assign core_done_mask = mask_q;
  assign all_done       = (state_q != S_RUN);
  assign test_pass      = (state_q == S_PASS);
  assign test_fail      = (state_q == S_FAIL);
  assign timeout        = (state_q == S_TIMEOUT);
  assign fail_core      = fail_core_q;
  assign fail_code      = fail_code_q;
  assign cycle_count    = cnt_q;

endmodule

// File: tb/tb_core_status_collector.sv
// tb/tb_core_status_collector.sv - directed self-checking bench for core_status_collector
module tb_core_status_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   core_wr_valid;
  logic [127:0] core_wr_data;
  logic [3:0]   core_wr_ready;
  logic [3:0]   core_done_mask;
  logic         all_done, test_pass, test_fail, timeout;
  logic [1:0]   fail_core;
  logic [30:0]  fail_code;
  logic [6:0]   cycle_count;
`ifdef COLLECTOR_CONSOLE_EN
  logic         char_valid;
  logic [7:0]   char_data;
`endif

  int errors = 0;
  int checks = 0;

  core_status_collector dut (
    .clk(clk), .reset(reset),
    .core_wr_valid(core_wr_valid), .core_wr_data(core_wr_data),
    .core_wr_ready(core_wr_ready), .core_done_mask(core_done_mask),
    .all_done(all_done), .test_pass(test_pass), .test_fail(test_fail),
    .timeout(timeout), .fail_core(fail_core), .fail_code(fail_code),
`ifdef COLLECTOR_CONSOLE_EN
    .char_valid(char_valid), .char_data(char_data),
`endif
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int core, input logic [31:0] data);
    core_wr_valid[core] = 1'b1;
    core_wr_data[core*32 +: 32] = data;
  endtask

  task automatic idle();
    core_wr_valid = '0;
    core_wr_data  = '0;
  endtask

  // Pulse reset away from the clock edge and leave the design in RUN with count 0.
  task automatic do_reset();
    idle();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
    chk(tag, {60'd0, all_done, test_pass, test_fail, timeout}, {60'd0, exp});
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #12;
    reset = 1'b1;
    #1;
    chk("rst_mask", core_done_mask, 0);
    chk_flags("rst_flags", 4'b0000);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_ready", core_wr_ready, 0);

    // 1: cores report done one per cycle
    tick(); tick();
    chk("t1_cnt2", cycle_count, 2);
    for (int i = 0; i < 4; i++) begin
      idle();
      wr(i, 32'h1);
      #1;
      chk("t1_ready", core_wr_ready, 64'(1 << i));
      tick();
      chk("t1_mask", core_done_mask, 64'((1 << (i + 1)) - 1));
    end
    idle();
    chk_flags("t1_pass", 4'b1100);
    chk("t1_cnt", cycle_count, 6);
    tick(); tick();
    chk("t1_cnt_frozen", cycle_count, 6);

    // 2: failing report latches core/code; later reports are dropped
    do_reset();
    wr(2, 32'h7);
    #1;
    chk("t2_ready2", core_wr_ready, 4'b0100);
    tick();
    idle();
    chk_flags("t2_fail", 4'b1010);
    chk("t2_core", fail_core, 2);
    chk("t2_code", fail_code, 3);
    wr(1, 32'h5);
    #1;
    chk("t2_ready1", core_wr_ready, 4'b0010);
    tick();
    idle();
    chk("t2_core_keep", fail_core, 2);
    chk("t2_code_keep", fail_code, 3);
    chk_flags("t2_fail_keep", 4'b1010);

    // 3: all cores request together, rotation 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 32'h1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_ready", core_wr_ready, 64'(1 << i));
      chk_flags("t3_running", 4'b0000);
      tick();
    end
    chk_flags("t3_pass", 4'b1100);
    chk("t3_mask", core_done_mask, 4'hF);
    chk("t3_ready_after", core_wr_ready, 4'b0001);
    idle();

    // 4: timeout with no writes
    do_reset();
    for (int i = 0; i < 99; i++) tick();
    chk("t4_cnt99", cycle_count, 99);
    chk_flags("t4_not_yet", 4'b0000);
    tick();
    chk_flags("t4_timeout", 4'b1001);
    chk("t4_cnt", cycle_count, 100);
    tick();
    chk("t4_cnt_frozen", cycle_count, 100);

    // accept on the last RUN cycle beats timeout
    do_reset();
    for (int i = 0; i < 99; i++) tick();
    wr(0, 32'h3);
    tick();
    idle();
    chk_flags("tb_accept_wins", 4'b1010);
    chk("tb_accept_cnt", cycle_count, 100);
    chk("tb_accept_code", fail_code, 1);

    // 5: duplicate report ignored, then async reset mid-run
    do_reset();
    wr(0, 32'h1); tick(); idle();
    wr(1, 32'h1); tick(); idle();
    wr(0, 32'h3); tick(); idle();
    chk("t5_mask", core_done_mask, 4'b0011);
    chk_flags("t5_dup_ignored", 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_rst_mask", core_done_mask, 0);
    chk("t5_rst_cnt", cycle_count, 0);
    reset = 1'b1;
    tick();
    chk("t5_restart_cnt", cycle_count, 1);

    // 6: console word
    do_reset();
    wr(0, 32'h48);
    #1;
    chk("t6_ready", core_wr_ready, 4'b0001);
    tick();
    idle();
    chk("t6_mask", core_done_mask, 0);
    chk_flags("t6_flags", 4'b0000);
`ifdef COLLECTOR_CONSOLE_EN
    chk("t6_char_valid", char_valid, 1);
    chk("t6_char_data", char_data, 8'h48);
    tick();
    chk("t6_char_pulse", char_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
